// File: rtl/onehot_pkg.sv
// Shared constants and helpers for the one-hot monitor.
// Holds the acceptance-mode encodings, the monitor state type and the population-count width rule.
package onehot_pkg;

    localparam logic [1:0] MODE_EXACT1  = 2'd0;
    localparam logic [1:0] MODE_ATMOST1 = 2'd1;
    localparam logic [1:0] MODE_ZERO    = 2'd2;

    typedef logic [0:0] mon_state_t;
    localparam mon_state_t MON_OK  = 1'b0;
    localparam mon_state_t MON_ERR = 1'b1;

    // Width needed to hold a population count of 0..n
    function automatic int pcnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/onehot_monitor_popcount_tree.sv
// Combinational population count built as a balanced binary adder tree.
// The tree recursively splits the input word in halves and sums the two partial counts.
module popcount_tree
    import onehot_pkg::*;
#(
    parameter int N = 5,
    parameter int W = pcnt_width(N)
) (
    input  logic [N-1:0] x,
    output logic [W-1:0] cnt
);

    generate
        if (N == 1) begin : g_leaf
            assign cnt = W'(x);
        end else begin : g_split
            localparam int NL = N / 2;
            localparam int NR = N - NL;
            localparam int WL = pcnt_width(NL);
            localparam int WR = pcnt_width(NR);

            logic [WL-1:0] cnt_lo_s;
            logic [WR-1:0] cnt_hi_s;

            popcount_tree #(.N(NL), .W(WL)) u_lo (.x(x[NL-1:0]), .cnt(cnt_lo_s));
            popcount_tree #(.N(NR), .W(WR)) u_hi (.x(x[N-1:NL]), .cnt(cnt_hi_s));

            // Each half fits its own narrower width, so the sum cannot overflow W
            assign cnt = W'(cnt_lo_s) + W'(cnt_hi_s);
        end
    endgenerate

endmodule

// File: rtl/onehot_monitor.sv
// Two-stage 1-of-N code checker with a selectable acceptance mode and sticky diagnostics.
// Stage 1 registers the word and its population count; stage 2 issues the verdict and updates the error state.
module onehot_monitor
    import onehot_pkg::*;
#(
    parameter int N     = 5,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    input  logic [N-1:0]           x,
    output logic                   out_valid,
    output logic                   y,
    output logic [$clog2(N+1)-1:0] pcnt,
    output logic                   err_sticky,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [N-1:0]           err_word
);

    localparam int               PW        = $clog2(N + 1);
    localparam logic [PW-1:0]    PCNT_ONE  = PW'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_STEP  = CNT_W'(1'b1);

    logic [PW-1:0]    pcnt_s;
    logic             ok_s;
    logic             s1_valid_r;
    logic [N-1:0]     s1_word_r;
    logic [1:0]       s1_mode_r;
    logic [PW-1:0]    s1_pcnt_r;
    logic             out_valid_r;
    logic             y_r;
    logic [PW-1:0]    pcnt_r;
    logic             err_sticky_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [N-1:0]     err_word_r;
    mon_state_t       state_r;

    popcount_tree #(.N(N), .W(PW)) u_popcount (.x(x), .cnt(pcnt_s));

    // Stage 1: capture word, its mode and its count; idle cycles just clear the valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_word_r  <= '0;
            s1_mode_r  <= 2'b00;
            s1_pcnt_r  <= '0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_word_r <= x;
                s1_mode_r <= mode;
                s1_pcnt_r <= pcnt_s;
            end else begin
                s1_word_r <= s1_word_r;
                s1_mode_r <= s1_mode_r;
                s1_pcnt_r <= s1_pcnt_r;
            end
        end
    end

    // Verdict for the word in stage 1; the reserved mode falls back to exactly-one
    always_comb begin
        ok_s = 1'b0;
        case (s1_mode_r)
            MODE_ATMOST1: ok_s = (s1_pcnt_r <= PCNT_ONE);
            MODE_ZERO:    ok_s = (s1_pcnt_r == '0);
            default:      ok_s = (s1_pcnt_r == PCNT_ONE);
        endcase
    end

    // Stage 2: verdict and count are held between valid words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            y_r         <= 1'b0;
            pcnt_r      <= '0;
        end else begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                y_r    <= ok_s;
                pcnt_r <= s1_pcnt_r;
            end else begin
                y_r    <= y_r;
                pcnt_r <= pcnt_r;
            end
        end
    end

    // Error path: clr takes priority so a coinciding rejection is dropped entirely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= MON_OK;
            err_sticky_r <= 1'b0;
            err_cnt_r    <= '0;
            err_word_r   <= '0;
        end else if (clr) begin
            state_r      <= MON_OK;
            err_sticky_r <= 1'b0;
            err_cnt_r    <= '0;
            err_word_r   <= '0;
        end else if (s1_valid_r && !ok_s) begin
            if (err_cnt_r != CNT_MAX) begin
                err_cnt_r <= err_cnt_r + CNT_STEP;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            case (state_r)
                MON_OK: begin
                    state_r      <= MON_ERR;
                    err_sticky_r <= 1'b1;
                    err_word_r   <= s1_word_r;
                end
                default: begin
                    state_r      <= MON_ERR;
                    err_sticky_r <= err_sticky_r;
                    err_word_r   <= err_word_r;
                end
            endcase
        end else begin
            state_r      <= state_r;
            err_sticky_r <= err_sticky_r;
            err_cnt_r    <= err_cnt_r;
            err_word_r   <= err_word_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign y          = y_r;
    assign pcnt       = pcnt_r;
    assign err_sticky = err_sticky_r;
    assign err_cnt    = err_cnt_r;
    assign err_word   = err_word_r;

endmodule

// File: tb/tb_onehot_monitor.sv
// Self-checking bench for onehot_monitor: directed scenarios plus a randomized stream
// compared against a word-level reference model; a second instance uses a 2-bit counter.
module tb_onehot_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       in_valid = 1'b0;
    logic [4:0] x = 5'd0;

    logic       out_valid, y, err_sticky;
    logic [2:0] pcnt;
    logic [7:0] err_cnt;
    logic [4:0] err_word;
    logic       s_out_valid, s_y, s_err_sticky;
    logic [2:0] s_pcnt;
    logic [1:0] s_err_cnt;
    logic [4:0] s_err_word;

    int checks = 0;
    int passed = 0;

    // Reference model: the word sitting between the two edges, last verdict, and error statistics
    logic       m_prev_valid;
    logic [1:0] m_prev_mode;
    logic [4:0] m_prev_x;
    logic       m_ov, m_y;
    logic [2:0] m_pcnt;
    int         m_err_n;
    logic [4:0] m_first;

    onehot_monitor #(.N(5), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .in_valid(in_valid), .x(x),
        .out_valid(out_valid), .y(y), .pcnt(pcnt), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .err_word(err_word));

    onehot_monitor #(.N(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .in_valid(in_valid), .x(x),
        .out_valid(s_out_valid), .y(s_y), .pcnt(s_pcnt), .err_sticky(s_err_sticky),
        .err_cnt(s_err_cnt), .err_word(s_err_word));

    always #5 clk = ~clk;

    function automatic logic accepts(input logic [1:0] md, input logic [4:0] w);
        int p;
        p = $countones(w);
        if (md == 2'd1) return (p <= 1);
        else if (md == 2'd2) return (p == 0);
        else return (p == 1);
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_prev_valid = 1'b0; m_prev_mode = 2'd0; m_prev_x = 5'd0;
        m_ov = 1'b0; m_y = 1'b0; m_pcnt = 3'd0; m_err_n = 0; m_first = 5'd0;
    endtask

    // Apply one cycle of inputs, advance past the edge and update the model
    task automatic step(input logic v, input logic [1:0] md, input logic [4:0] w, input logic c);
        in_valid = v; mode = md; x = w; clr = c;
        @(posedge clk);
        #1;
        m_ov = m_prev_valid;
        if (m_prev_valid) begin
            m_y    = accepts(m_prev_mode, m_prev_x);
            m_pcnt = 3'($countones(m_prev_x));
            if (!m_y && !c) begin
                if (m_err_n == 0) m_first = m_prev_x;
                m_err_n++;
            end
        end
        if (c) begin
            m_err_n = 0;
            m_first = 5'd0;
        end
        m_prev_valid = v; m_prev_mode = md; m_prev_x = w;
        in_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({out_valid, y, pcnt} !== 5'b0) $display("FAIL reset_out got=%b want=00000", {out_valid, y, pcnt}); else passed++;
        checks++; if ({err_sticky, err_cnt, err_word} !== 14'b0) $display("FAIL reset_err got=%h want=0", {err_sticky, err_cnt, err_word}); else passed++;
        checks++; if ({s_out_valid, s_err_cnt} !== 3'b0) $display("FAIL reset_sat got=%b want=000", {s_out_valid, s_err_cnt}); else passed++;
        rst_n = 1'b1;
        step(1'b0, 2'd0, 5'd0, 1'b0);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_idle_ov got=%b want=0", out_valid); else passed++;
    endtask

    task automatic test_exact1_stream();
        logic [4:0] words [5] = '{5'b00001, 5'b00100, 5'b10000, 5'b00000, 5'b00011};
        logic       exp_y [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        step(1'b0, 2'd0, 5'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(i < 5, 2'd0, (i < 5) ? words[i] : 5'd0, 1'b0);
            if (i > 0) begin
                checks++; if ({out_valid, y} !== {1'b1, exp_y[i-1]}) $display("FAIL exact1_y[%0d] got=%b%b want=1%b", i-1, out_valid, y, exp_y[i-1]); else passed++;
                checks++; if (y !== m_y) $display("FAIL exact1_model[%0d] got=%b want=%b", i-1, y, m_y); else passed++;
            end
        end
        checks++; if ({err_sticky, err_cnt, err_word} !== {1'b1, 8'd2, 5'b00000}) $display("FAIL exact1_err got=%b/%0d/%b want=1/2/00000", err_sticky, err_cnt, err_word); else passed++;
    endtask

    task automatic test_atmost1();
        logic [4:0] words [3] = '{5'b00000, 5'b01000, 5'b01010};
        logic [3:0] exp_yp [3] = '{4'b1000, 4'b1001, 4'b0010};
        step(1'b0, 2'd0, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(i < 3, 2'd1, (i < 3) ? words[i] : 5'd0, 1'b0);
            if (i > 0) begin
                checks++; if ({y, pcnt} !== exp_yp[i-1]) $display("FAIL atmost1[%0d] got y,pcnt=%b want=%b", i-1, {y, pcnt}, exp_yp[i-1]); else passed++;
            end
        end
        checks++; if (err_cnt !== 8'd1) $display("FAIL atmost1_cnt got=%0d want=1", err_cnt); else passed++;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(1'b0, 2'd0, 5'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(i < 5, 2'd0, 5'b11111, 1'b0);
            if (i > 0) begin
                checks++; if (s_err_cnt !== exp_c[i-1]) $display("FAIL sat_cnt[%0d] got=%0d want=%0d", i-1, s_err_cnt, exp_c[i-1]); else passed++;
            end
        end
        checks++; if ({s_err_word, err_cnt} !== {5'b11111, 8'd5}) $display("FAIL sat_word got=%b/%0d want=11111/5", s_err_word, err_cnt); else passed++;
    endtask

    task automatic test_clr_collision();
        step(1'b0, 2'd0, 5'd0, 1'b1);
        step(1'b1, 2'd0, 5'b00011, 1'b0);
        step(1'b0, 2'd0, 5'd0, 1'b1);
        checks++; if ({out_valid, y, err_sticky, err_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) $display("FAIL clr_collide got ov,y,st,cnt=%b%b%b/%0d want=100/0", out_valid, y, err_sticky, err_cnt); else passed++;
        step(1'b1, 2'd0, 5'b10100, 1'b0);
        step(1'b0, 2'd0, 5'd0, 1'b0);
        checks++; if ({err_sticky, err_cnt, err_word} !== {1'b1, 8'd1, 5'b10100}) $display("FAIL clr_next got=%b/%0d/%b want=1/1/10100", err_sticky, err_cnt, err_word); else passed++;
    endtask

    task automatic test_gapped_mode();
        int         nvalid = 0;
        logic       v_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] m_seq [6] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
        logic       y_seen [$];
        for (int i = 0; i < 6; i++) begin
            step(v_seq[i], m_seq[i], 5'b00000, 1'b0);
            if (out_valid) begin nvalid++; y_seen.push_back(y); end
            checks++; if ({out_valid, y} !== {m_ov, m_y}) $display("FAIL gapped[%0d] got=%b%b want=%b%b", i, out_valid, y, m_ov, m_y); else passed++;
        end
        checks++; if (nvalid !== 2 || y_seen.size() != 2 || y_seen[0] !== 1'b0 || y_seen[1] !== 1'b1) $display("FAIL gapped_count got=%0d valids want=2 with y=0,1", nvalid); else passed++;
    endtask

    task automatic test_reset_inflight();
        step(1'b1, 2'd0, 5'b00011, 1'b0);
        step(1'b1, 2'd1, 5'b00001, 1'b0);
        checks++; if (err_cnt !== 8'(min_int(m_err_n, 255))) $display("FAIL pre_reset_cnt got=%0d want=%0d", err_cnt, m_err_n); else passed++;
        in_valid = 1'b1; x = 5'b11000; mode = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, y, pcnt, err_sticky, err_cnt, err_word} !== 19'b0) $display("FAIL async_reset got=%h want=0", {out_valid, y, pcnt, err_sticky, err_cnt, err_word}); else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 5'd0, 1'b0);
            checks++; if (out_valid !== 1'b0) $display("FAIL post_reset_ov[%0d] got=%b want=0", i, out_valid); else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) != 0) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom),
                 ($urandom_range(0, 24) == 0));
            checks++; if ({out_valid, y, pcnt} !== {m_ov, m_y, m_pcnt}) $display("FAIL rand_out[%0d] got=%b want=%b", i, {out_valid, y, pcnt}, {m_ov, m_y, m_pcnt}); else passed++;
            checks++; if ({err_sticky, err_cnt, err_word} !== {(m_err_n > 0), 8'(min_int(m_err_n, 255)), m_first}) $display("FAIL rand_err[%0d] got=%b/%0d/%b want=%b/%0d/%b", i, err_sticky, err_cnt, err_word, (m_err_n > 0), m_err_n, m_first); else passed++;
            checks++; if ({s_err_sticky, s_err_cnt, s_err_word} !== {(m_err_n > 0), 2'(min_int(m_err_n, 3)), m_first}) $display("FAIL rand_sat[%0d] got=%b/%0d/%b want=%0d", i, s_err_sticky, s_err_cnt, s_err_word, min_int(m_err_n, 3)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_exact1_stream();
        test_atmost1();
        test_saturation();
        test_clr_collision();
        test_gapped_mode();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
